// File: rtl/rotate_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : rotate_sequencer_if
// Brief   : Request/result handshake bundle for rotate_sequencer.
// Rev     : 1.0
// ============================================================================
interface rotate_sequencer_if #(
  parameter int W = 4
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [1:0]   in_amt;
  logic         in_dir;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         busy;

  modport master (
    output in_valid, in_data, in_amt, in_dir, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_dir, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface
`default_nettype wire

// File: rtl/barrel_shifter_1.sv
`default_nettype none
// ============================================================================
// Module  : barrel_shifter_1
// Brief   : Single-position 4-bit left rotator; passes through when idle.
// Rev     : 1.0
// ============================================================================
module barrel_shifter_1 (
  input  wire logic [3:0] a,
  input  wire logic       select,
  output      logic [3:0] y
);
  assign y = select ? {a[2:0], a[3]} : a;
endmodule
`default_nettype wire

// File: rtl/rotate_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : rotate_sequencer
// Brief   : Applies a 0-3 step rotation by iterating barrel_shifter_1.
// Rev     : 1.0
// ============================================================================
module rotate_sequencer #(
  parameter int W = 4
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  rotate_sequencer_if.slave  bus
);
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ROT  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_state_next;
  logic [W-1:0] r_data;
  logic [W-1:0] w_data_next;
  logic [W-1:0] w_shift;
  logic [1:0]   r_cnt;
  logic [1:0]   w_cnt_next;
  logic [1:0]   w_eff;
  logic         w_rot_en;

  // Right by n is left by (4 - n) mod 4; 2-bit negation gives the wrap for free.
  assign w_eff    = bus.in_dir ? (2'd0 - bus.in_amt) : bus.in_amt;
  assign w_rot_en = (r_state == ST_ROT);

  barrel_shifter_1 u_shift (
    .a      (r_data),
    .select (w_rot_en),
    .y      (w_shift)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_data  <= '0;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_state_next;
      r_data  <= w_data_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_data_next  = r_data;
    w_cnt_next   = r_cnt;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.in_valid) begin
          w_data_next  = bus.in_data;
          w_cnt_next   = w_eff;
          w_state_next = (w_eff == 2'd0) ? ST_HOLD : ST_ROT;
        end
      end
      ST_ROT: begin
        w_data_next = w_shift;
        w_cnt_next  = r_cnt - 2'd1;
        if (r_cnt == 2'd1) begin
          w_state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (bus.out_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.out_valid = (r_state == ST_HOLD);
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.out_data  = r_data;
endmodule
`default_nettype wire

// File: tb/tb_rotate_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_rotate_sequencer
// Brief   : Scoreboard bench for rotate_sequencer; drives and samples on negedge.
// Rev     : 1.0
// ============================================================================
module tb_rotate_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   tests = 0;
  int   fails = 0;
  logic [3:0] sb[$];

  rotate_sequencer_if #(.W(4)) bus ();

  rotate_sequencer #(.W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] rot_model(input logic [3:0] d, input logic [1:0] a,
                                           input logic dir);
    logic [3:0] r;
    r = d;
    for (int i = 0; i < int'(a); i++) begin
      r = dir ? {r[0], r[3:1]} : {r[2:0], r[3]};
    end
    return r;
  endfunction

  function automatic int lat_model(input logic [1:0] a, input logic dir);
    return dir ? ((4 - int'(a)) % 4) : int'(a);
  endfunction

  task automatic test_reset();
    bus.in_valid  = 1'($urandom);
    bus.in_data   = 4'($urandom);
    bus.in_amt    = 2'($urandom);
    bus.in_dir    = 1'($urandom);
    bus.out_ready = 1'($urandom);
    #2 rst_n = 1'b0;
    #1;
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready got=%b exp=1", bus.in_ready); end
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    tests++; if (bus.out_data !== 4'h0) begin fails++; $display("FAIL rst_out_data got=%h exp=0", bus.out_data); end
    repeat (3) @(negedge clk);
    tests++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++; $display("FAIL rst_hold got valid=%b ready=%b exp 0/1", bus.out_valid, bus.in_ready);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    rst_n = 1'b1;
  endtask

  // Issue one request at the current negedge, check latency and result.
  task automatic run_req(input logic [3:0] d, input logic [1:0] a, input logic dir,
                         input string name);
    int lat;
    int exp_lat;
    logic [3:0] exp;
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL %s_in_ready got=%b exp=1", name, bus.in_ready); end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_amt   = a;
    bus.in_dir   = dir;
    sb.push_back(rot_model(d, a, dir));
    exp_lat = lat_model(a, dir);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    tests++; if (lat != exp_lat) begin fails++; $display("FAIL %s_latency got=%0d exp=%0d", name, lat, exp_lat); end
    exp = sb.pop_front();
    tests++; if (bus.out_data !== exp) begin fails++; $display("FAIL %s_data got=%b exp=%b", name, bus.out_data, exp); end
    @(negedge clk);
  endtask

  task automatic test_left();
    logic [1:0] a;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = 2'(i);
      run_req(4'b1010, a, 1'b0, $sformatf("left%0d", i));
    end
  endtask

  task automatic test_right();
    logic [1:0] amts [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    bus.out_ready = 1'b1;
    foreach (amts[i]) run_req(4'b0001, amts[i], 1'b1, $sformatf("right%0d", amts[i]));
  endtask

  task automatic test_backpressure();
    int wait_cnt;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 4'b0011;
    bus.in_amt    = 2'd1;
    bus.in_dir    = 1'b0;
    sb.push_back(rot_model(4'b0011, 2'd1, 1'b0));
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_cnt = 0;
    while (bus.out_valid !== 1'b1 && wait_cnt < 10) begin
      @(negedge clk);
      wait_cnt++;
    end
    tests++; if (wait_cnt != 1) begin fails++; $display("FAIL bp_latency got=%0d exp=1", wait_cnt); end
    for (int i = 0; i < 5; i++) begin
      tests++; if (bus.out_valid !== 1'b1 || bus.out_data !== sb[0] || bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
        fails++;
        $display("FAIL bp_stall%0d got valid=%b data=%b ready=%b busy=%b exp 1/%b/0/1",
                 i, bus.out_valid, bus.out_data, bus.in_ready, bus.busy, sb[0]);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = 4'hF;
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    tests++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      fails++; $display("FAIL bp_release got ready=%b valid=%b busy=%b exp 1/0/0", bus.in_ready, bus.out_valid, bus.busy);
    end
    tests++; if (bus.out_data !== sb[0]) begin fails++; $display("FAIL bp_no_take got=%b exp=%b", bus.out_data, sb[0]); end
    void'(sb.pop_front());
  endtask

  task automatic test_input_change();
    int n;
    logic [3:0] exp;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 4'b0101;
    bus.in_amt    = 2'd3;
    bus.in_dir    = 1'b0;
    sb.push_back(rot_model(4'b0101, 2'd3, 1'b0));
    @(negedge clk);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 10) begin
      bus.in_valid = 1'($urandom);
      bus.in_data  = 4'($urandom);
      bus.in_amt   = 2'($urandom);
      bus.in_dir   = 1'($urandom);
      @(negedge clk);
      n++;
    end
    bus.in_valid = 1'b0;
    exp = sb.pop_front();
    tests++; if (n != 3) begin fails++; $display("FAIL chg_latency got=%0d exp=3", n); end
    tests++; if (bus.out_data !== exp) begin fails++; $display("FAIL chg_data got=%b exp=%b", bus.out_data, exp); end
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 4'b1010;
    bus.in_amt    = 2'd3;
    bus.in_dir    = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL mid_busy_before got=%b exp=1", bus.busy); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.out_data !== 4'h0) begin
      fails++;
      $display("FAIL mid_reset got ready=%b valid=%b busy=%b data=%h exp 1/0/0/0",
               bus.in_ready, bus.out_valid, bus.busy, bus.out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++; $display("FAIL mid_reset_after got valid=%b ready=%b exp 0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int sent;
    int got;
    int cyc;
    logic [3:0] exp;
    sent = 0;
    got  = 0;
    cyc  = 0;
    bus.in_valid = 1'b1;
    while (got < 20 && cyc < 1000) begin
      tests++; if (bus.busy !== !bus.in_ready) begin
        fails++; $display("FAIL b2b_busy got busy=%b ready=%b", bus.busy, bus.in_ready);
      end
      bus.out_ready = ($urandom_range(0, 2) != 0);
      if (bus.out_valid === 1'b1 && bus.out_ready) begin
        if (sb.size() == 0) begin
          tests++; fails++; $display("FAIL b2b_extra got=%b exp=none", bus.out_data);
        end else begin
          exp = sb.pop_front();
          tests++; if (bus.out_data !== exp) begin fails++; $display("FAIL b2b_data%0d got=%b exp=%b", got, bus.out_data, exp); end
        end
        got++;
      end
      bus.in_data = 4'($urandom);
      bus.in_amt  = 2'($urandom);
      bus.in_dir  = 1'($urandom);
      if (sent < 20) begin
        if (bus.in_ready === 1'b1) begin
          sb.push_back(rot_model(bus.in_data, bus.in_amt, bus.in_dir));
          sent++;
        end
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.in_valid = 1'b0;
    tests++; if (got != 20 || sb.size() != 0) begin
      fails++; $display("FAIL b2b_count got=%0d left=%0d exp=20/0", got, sb.size());
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 4'h0;
    bus.in_amt    = 2'd0;
    bus.in_dir    = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    @(negedge clk);
    test_left();
    test_right();
    test_backpressure();
    test_input_change();
    test_mid_reset();
    sb.delete();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/rotate_sequencer.md
# rotate_sequencer

Multi-step rotation controller placed directly upstream of `barrel_shifter_1`, the single-position 4-bit rotator. It accepts a 4-bit word, a rotate amount and a direction through a valid/ready handshake. It drives `barrel_shifter_1` once per clock and feeds each result back into an internal register until the requested amount is applied. The final word is then presented on a valid/ready output port.

## Interface
Parameters:
- `W`, 4: data width. Fixed at 4 to match `barrel_shifter_1`; other values are unsupported.

Ports:
- `clk`  input  1  rising-edge clock; the only clock in the block.
- `rst_n`  input  1  reset, asynchronous assert, active-low.
- `in_valid`  input  1  a request is present on `in_data`/`in_amt`/`in_dir`.
- `in_ready`  output  1  block can accept a request; high only in IDLE.
- `in_data`  input  4  word to rotate.
- `in_amt`  input  2  rotate amount, 0–3 positions.
- `in_dir`  input  1  rotate direction: 0 = left, 1 = right.
- `out_valid`  output  1  `out_data` holds a finished result; high only in HOLD.
- `out_ready`  input  1  the consumer takes the result.
- `out_data`  output  4  rotated word; equals the internal data register at all times.
- `busy`  output  1  high in ROT or HOLD.

## Operation
- Internal state:
  - `data_q[3:0]`, the working register.
  - `cnt_q[1:0]`, the remaining steps.
  - FSM state: IDLE, ROT or HOLD.
- Shifter hookup:
  - `barrel_shifter_1` is instantiated with `a = data_q`.
  - Its `select` input is driven by `(state == ROT)`.
  - With `select = 1` it outputs `{a[2:0], a[3]}` (rotate left by 1). With `select = 0` it outputs `a`.
- Effective left steps: `eff = in_dir ? (4 - in_amt) mod 4 : in_amt`. This is a 2-bit wrap-around: right by 1 becomes left by 3, and right by 0 becomes 0.
- IDLE:
  - `in_ready = 1`.
  - On `in_valid`, at the clock edge: `data_q <= in_data`, `cnt_q <= eff`, next state is HOLD if `eff == 0`, otherwise ROT.
- ROT:
  - Each edge: `data_q <=` shifter output and `cnt_q <= cnt_q - 1`.
  - When `cnt_q == 1`, the next state is HOLD.
  - `in_valid` is ignored.
- HOLD:
  - `out_valid = 1`; `data_q` is frozen.
  - When `out_ready` is sampled high, the next state is IDLE.
  - A new request cannot be accepted in the same cycle: `in_ready` stays 0 in HOLD.
- `out_data` reflects `data_q` in every state. It is only meaningful while `out_valid` is high.
- `in_amt` and `in_dir` are captured only at acceptance. Later changes to them have no effect.

## Timing
- Reset (`rst_n` low, asynchronous):
  - state IDLE, `data_q = 0`, `cnt_q = 0`.
  - Outputs: `in_ready = 1`, `out_valid = 0`, `busy = 0`, `out_data = 4'h0`.
- Release: reset is deasserted synchronously by the system. The first acceptance can occur at the first rising edge after release.
- Latency: a request accepted at edge E0 gives `out_valid` high after edge E0 + eff. With eff = 0, `out_valid` is high in the cycle right after E0.
- Throughput: one request per eff + 2 cycles minimum, when `out_ready` is held high.
- Backpressure: HOLD lasts any number of cycles. `out_data` and `out_valid` stay stable until the handshake.
- Reset mid-operation: asserting `rst_n` in ROT or HOLD aborts immediately. Outputs return to their reset values, and no partial result is ever flagged valid.
- `busy` is low exactly when `in_ready` is high.

## Test plan
- Reset: hold `rst_n = 0` with random inputs -> `in_ready = 1`, `out_valid = 0`, `busy = 0`, `out_data = 0`. Assert reset mid-ROT -> the same values take effect immediately, without waiting for a clock edge.
- Left rotations: `in_data = 4'b1010`, `in_dir = 0`, `in_amt = 0/1/2/3`, `out_ready = 1`:
  - results 1010 / 0101 / 1010 / 0101;
  - `out_valid` rises exactly 0/1/2/3 cycles after the acceptance edge.
- Right rotations: `in_data = 4'b0001`, `in_dir = 1`, `in_amt = 1/2/3/0` -> results 1000 / 0100 / 0010 / 0001. Right by 1 must take 3 ROT cycles.
- Backpressure: `in_data = 4'b0011`, left by 1, `out_ready` low for 5 cycles:
  - `out_data = 0110` and `out_valid` stay stable for all 5 cycles;
  - `in_ready = 0` throughout, and a concurrent `in_valid` with `in_data = 4'hF` is not taken;
  - raising `out_ready` -> IDLE on the next cycle.
- Input change during ROT: accept `in_data = 4'b0101`, left by 3, then change `in_data`/`in_amt`/`in_dir` each cycle -> result is 1010, unaffected by the changes.
- Back-to-back: 20 random requests with `in_valid` held high and random `out_ready` stalls -> every result matches a scoreboard rotate model, in order, with none lost or duplicated.
